// File: rtl/pll_sup_pkg.sv
// Shared types and helpers for the PLL lock supervisor: FSM state encoding,
// the registered output bundle, and the counter-width helper.
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLL_RST   = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_STABLE    = 3'd2,
    ST_RUN       = 3'd3,
    ST_FAULT     = 3'd4
  } state_t;

  typedef struct packed {
    logic pll_areset;
    logic sys_rst_n;
    logic ready;
    logic fault;
  } out_t;

  // Width that holds the largest of three terminal counts without wrapping.
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return $clog2(m + 1);
  endfunction

  // Output values that belong to a state, so they can be registered on entry.
  function automatic out_t outs_of(input state_t s);
    out_t o;
    o.pll_areset = (s == ST_PLL_RST) || (s == ST_FAULT);
    o.sys_rst_n  = (s == ST_RUN);
    o.ready      = (s == ST_RUN);
    o.fault      = (s == ST_FAULT);
    return o;
  endfunction

endpackage

// File: rtl/pll_lock_supervisor_if.sv
// Status/control bundle between the lock supervisor and the PLL plus the
// downstream reset consumers.
interface pll_lock_supervisor_if #(
  parameter int LOSS_CNT_W = 8
);
  logic                  locked_in;
  logic                  pll_areset;
  logic                  sys_rst_n;
  logic                  ready;
  logic                  fault;
  logic [LOSS_CNT_W-1:0] lock_loss_cnt;

  modport master (
    input  locked_in,
    output pll_areset, sys_rst_n, ready, fault, lock_loss_cnt
  );

  modport slave (
    output locked_in,
    input  pll_areset, sys_rst_n, ready, fault, lock_loss_cnt
  );
endinterface

// File: rtl/pll_lock_supervisor_sync_bit.sv
// N-flop single-bit synchronizer, cleared asynchronously; also used by the
// downstream reset-release synchronizers.
module sync_bit #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_p;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[STAGES-2:0], d};
    end
  end

  assign q = sync_p[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// Holds the PLL in reset, qualifies its locked flag, and releases one clean
// active-low system reset; retries on lock timeout and latches a hard fault.
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int SYNC_STAGES         = 2,
  parameter int PLL_RST_CYCLES      = 16,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int LOCK_TIMEOUT_CYCLES = 65536,
  parameter int MAX_RETRIES         = 4,
  parameter int LOSS_CNT_W          = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  pll_lock_supervisor_if.master  bus
);

  localparam int CNT_W   = cnt_width(PLL_RST_CYCLES, LOCK_STABLE_CYCLES, LOCK_TIMEOUT_CYCLES);
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST     = CNT_W'(PLL_RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STABLE_DONE  = CNT_W'(LOCK_STABLE_CYCLES);
  localparam logic [RETRY_W-1:0] RETRY_LAST   = RETRY_W'(MAX_RETRIES - 1);

  function automatic logic [LOSS_CNT_W-1:0] sat_inc(input logic [LOSS_CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  logic                  lk_s;
  state_t                state;
  logic [CNT_W-1:0]      phase_cnt;
  logic [RETRY_W-1:0]    retry_cnt;
  logic [LOSS_CNT_W-1:0] loss_cnt;
  out_t                  outs;

  sync_bit #(
    .STAGES (SYNC_STAGES)
  ) u_lock_sync (
    .clk   (clk),
    .rst_n (rst),
    .d     (bus.locked_in),
    .q     (lk_s)
  );

  // Outputs are loaded from outs_of() of the state being entered, so every
  // output changes on the same edge as the state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_PLL_RST;
      phase_cnt <= '0;
      retry_cnt <= '0;
      loss_cnt  <= '0;
      outs      <= outs_of(ST_PLL_RST);
    end else begin
      unique case (state)
        ST_PLL_RST: begin
          if (phase_cnt == RST_LAST) begin
            state     <= ST_WAIT_LOCK;
            phase_cnt <= '0;
            outs      <= outs_of(ST_WAIT_LOCK);
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        ST_WAIT_LOCK: begin
          if (lk_s) begin
            state     <= ST_STABLE;
            phase_cnt <= '0;
            outs      <= outs_of(ST_STABLE);
          end else if (phase_cnt == TIMEOUT_LAST) begin
            phase_cnt <= '0;
            retry_cnt <= retry_cnt + 1'b1;
            if (retry_cnt == RETRY_LAST) begin
              state <= ST_FAULT;
              outs  <= outs_of(ST_FAULT);
            end else begin
              state <= ST_PLL_RST;
              outs  <= outs_of(ST_PLL_RST);
            end
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        // Release only after the full stable count has been observed with
        // lock still present; any drop restarts the qualification.
        ST_STABLE: begin
          if (!lk_s) begin
            state     <= ST_WAIT_LOCK;
            phase_cnt <= '0;
            outs      <= outs_of(ST_WAIT_LOCK);
          end else if (phase_cnt == STABLE_DONE) begin
            state     <= ST_RUN;
            phase_cnt <= '0;
            retry_cnt <= '0;
            outs      <= outs_of(ST_RUN);
          end else begin
            phase_cnt <= phase_cnt + 1'b1;
          end
        end

        // A loss of lock does not reset the PLL; it only re-qualifies.
        ST_RUN: begin
          if (!lk_s) begin
            state     <= ST_WAIT_LOCK;
            phase_cnt <= '0;
            loss_cnt  <= sat_inc(loss_cnt);
            outs      <= outs_of(ST_WAIT_LOCK);
          end
        end

        ST_FAULT: begin
          outs <= outs_of(ST_FAULT);
        end

        default: begin
          state     <= ST_PLL_RST;
          phase_cnt <= '0;
          outs      <= outs_of(ST_PLL_RST);
        end
      endcase
    end
  end

  assign bus.pll_areset    = outs.pll_areset;
  assign bus.sys_rst_n     = outs.sys_rst_n;
  assign bus.ready         = outs.ready;
  assign bus.fault         = outs.fault;
  assign bus.lock_loss_cnt = loss_cnt;

endmodule
